// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and colour constants.
// Used by the timing generator and by the game logic.
package vga_pkg;

  localparam int CLK_DIV_DEF      = 4;
  localparam int H_TOTAL_DEF      = 800;
  localparam int H_SYNC_DEF       = 96;
  localparam int H_DISP_START_DEF = 144;
  localparam int H_DISP_END_DEF   = 783;
  localparam int V_TOTAL_DEF      = 525;
  localparam int V_SYNC_DEF       = 2;
  localparam int V_DISP_START_DEF = 35;
  localparam int V_DISP_END_DEF   = 514;
  localparam int TICK_FRAMES_DEF  = 1;

  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic [11:0] BLACK  = 12'h000;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic rgb_t to_rgb(input logic [11:0] c);
    return rgb_t'(c);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-clock divider plus horizontal/vertical counters.
// Ports: clk, rst_n in; pix_en, hCount, vCount, frame_wrap out.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       frame_wrap
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [DW-1:0] div;
  logic          h_last;
  logic          v_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Gated by rst_n so CLK_DIV=1 cannot strobe while in reset.
  assign pix_en = rst_n & (div == DIV_LAST);
  assign h_last = (hCount == H_LAST);
  assign v_last = (vCount == V_LAST);
  assign frame_wrap = pix_en & h_last & v_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hCount <= '0;
        vCount <= v_last ? 10'd0 : vCount + 10'd1;
      end else begin
        hCount <= hCount + 10'd1;
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator with registered DAC outputs and game tick.
// Ports: clk, rst_n, rgb_in in; counters, syncs, colour, strobes out.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV      = CLK_DIV_DEF,
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_DISP_START = H_DISP_START_DEF,
  parameter int H_DISP_END   = H_DISP_END_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_DISP_START = V_DISP_START_DEF,
  parameter int V_DISP_END   = V_DISP_END_DEF,
  parameter int TICK_FRAMES  = TICK_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB,
  output logic        hSync,
  output logic        vSync,
  output logic        game_tick
);

  localparam int FW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(TICK_FRAMES - 1);

  logic          frame_wrap;
  logic          hs_raw;
  logic          vs_raw;
  logic [FW-1:0] frame_cnt;
  rgb_t          pix;

  vga_sync_counter #(
    .CLK_DIV (CLK_DIV),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .hCount     (hCount),
    .vCount     (vCount),
    .frame_wrap (frame_wrap)
  );

  assign bright = (hCount >= 10'(H_DISP_START))
                & (hCount <= 10'(H_DISP_END))
                & (vCount >= 10'(V_DISP_START))
                & (vCount <= 10'(V_DISP_END));

  assign hs_raw = ~(hCount < 10'(H_SYNC));
  assign vs_raw = ~(vCount < 10'(V_SYNC));
  assign pix    = bright ? to_rgb(rgb_in) : to_rgb(BLACK);

  // One pixel of latency on every DAC-side output keeps them aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vgaR  <= '0;
      vgaG  <= '0;
      vgaB  <= '0;
      hSync <= 1'b1;
      vSync <= 1'b1;
    end else if (pix_en) begin
      vgaR  <= pix.r;
      vgaG  <= pix.g;
      vgaB  <= pix.b;
      hSync <= hs_raw;
      vSync <= vs_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= (frame_cnt == F_LAST) ? '0 : frame_cnt + 1'b1;
    end
  end

  assign game_tick = frame_wrap & (frame_cnt == F_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster.
// 20x8 pixels, 4 clks/pixel, tick every 3 frames.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] rgb_in;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic        pix_en;
  logic [3:0]  vgaR;
  logic [3:0]  vgaG;
  logic [3:0]  vgaB;
  logic        hSync;
  logic        vSync;
  logic        game_tick;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV      (4),
    .H_TOTAL      (20),
    .H_SYNC       (3),
    .H_DISP_START (5),
    .H_DISP_END   (16),
    .V_TOTAL      (8),
    .V_SYNC       (2),
    .V_DISP_START (3),
    .V_DISP_END   (6),
    .TICK_FRAMES  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rgb_in    (rgb_in),
    .hCount    (hCount),
    .vCount    (vCount),
    .bright    (bright),
    .pix_en    (pix_en),
    .vgaR      (vgaR),
    .vgaG      (vgaG),
    .vgaB      (vgaB),
    .hSync     (hSync),
    .vSync     (vSync),
    .game_tick (game_tick)
  );

  typedef struct {
    int k;
    int h;
    int v;
    int pe;
    int br;
    int hs;
    int vs;
    int r;
    int gt;
  } vec_t;

  vec_t tbl[21];
  int errors = 0;
  int checks = 0;
  int k_now = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k_now++;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".h"}, int'(hCount), 0);
    chk({nm, ".v"}, int'(vCount), 0);
    chk({nm, ".hs"}, int'(hSync), 1);
    chk({nm, ".vs"}, int'(vSync), 1);
    chk({nm, ".r"}, int'(vgaR), 0);
    chk({nm, ".pe"}, int'(pix_en), 0);
    chk({nm, ".gt"}, int'(game_tick), 0);
  endtask

  initial begin
    int hlow;
    int pcnt;
    int vlow;
    int ticks;
    int tick_k;
    int first_k;

    // k = clock edges since reset release; pixel p = k/4.
    tbl[0]  = '{0,    0,  0, 0, 0, 1, 1, 0,  0};
    tbl[1]  = '{3,    0,  0, 1, 0, 1, 1, 0,  0};
    tbl[2]  = '{4,    1,  0, 0, 0, 0, 0, 0,  0};
    tbl[3]  = '{16,   4,  0, 0, 0, 1, 0, 0,  0};
    tbl[4]  = '{79,   19, 0, 1, 0, 1, 0, 0,  0};
    tbl[5]  = '{80,   0,  1, 0, 0, 1, 0, 0,  0};
    tbl[6]  = '{164,  1,  2, 0, 0, 0, 1, 0,  0};
    tbl[7]  = '{256,  4,  3, 0, 0, 1, 1, 0,  0};
    tbl[8]  = '{260,  5,  3, 0, 1, 1, 1, 0,  0};
    tbl[9]  = '{264,  6,  3, 0, 1, 1, 1, 15, 0};
    tbl[10] = '{544,  16, 6, 0, 1, 1, 1, 15, 0};
    tbl[11] = '{548,  17, 6, 0, 0, 1, 1, 15, 0};
    tbl[12] = '{552,  18, 6, 0, 0, 1, 1, 0,  0};
    tbl[13] = '{624,  16, 7, 0, 0, 1, 1, 0,  0};
    tbl[14] = '{639,  19, 7, 1, 0, 1, 1, 0,  0};
    tbl[15] = '{640,  0,  0, 0, 0, 1, 1, 0,  0};
    tbl[16] = '{644,  1,  0, 0, 0, 0, 0, 0,  0};
    tbl[17] = '{1279, 19, 7, 1, 0, 1, 1, 0,  0};
    tbl[18] = '{1918, 19, 7, 0, 0, 1, 1, 0,  0};
    tbl[19] = '{1919, 19, 7, 1, 0, 1, 1, 0,  1};
    tbl[20] = '{1920, 0,  0, 0, 0, 1, 1, 0,  0};

    rgb_in = RED;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    k_now = 0;

    for (int i = 0; i < 21; i++) begin
      while (k_now < tbl[i].k) step();
      chk($sformatf("v%0d.h", i), int'(hCount), tbl[i].h);
      chk($sformatf("v%0d.v", i), int'(vCount), tbl[i].v);
      chk($sformatf("v%0d.pe", i), int'(pix_en), tbl[i].pe);
      chk($sformatf("v%0d.br", i), int'(bright), tbl[i].br);
      chk($sformatf("v%0d.hs", i), int'(hSync), tbl[i].hs);
      chk($sformatf("v%0d.vs", i), int'(vSync), tbl[i].vs);
      chk($sformatf("v%0d.r", i), int'(vgaR), tbl[i].r);
      chk($sformatf("v%0d.g", i), int'(vgaG), 0);
      chk($sformatf("v%0d.b", i), int'(vgaB), 0);
      chk($sformatf("v%0d.gt", i), int'(game_tick), tbl[i].gt);
    end

    // One line: hSync low 3 pixels (12 clks), 20 strobes.
    hlow = 0;
    pcnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (!hSync) hlow++;
      if (pix_en) pcnt++;
      step();
    end
    chk("hsync_low_clks", hlow, 12);
    chk("pix_en_per_line", pcnt, 20);

    // Frame 4: vSync low 2 lines; one tick at the end of frame 5.
    while (k_now < 2560) step();
    vlow = 0;
    ticks = 0;
    tick_k = -1;
    while (k_now <= 3840) begin
      if (k_now < 3200 && !vSync) vlow++;
      if (game_tick) begin
        ticks++;
        tick_k = k_now;
        chk("tick_h", int'(hCount), 19);
        chk("tick_v", int'(vCount), 7);
        chk("tick_pe", int'(pix_en), 1);
      end
      step();
    end
    chk("vsync_low_clks", vlow, 160);
    chk("tick_count", ticks, 1);
    chk("tick_k", tick_k, 3839);

    // Mid-frame async reset at pixel (10,4).
    while (k_now < 4202) step();
    chk("mid.h", int'(hCount), 10);
    chk("mid.v", int'(vCount), 4);
    chk("mid.br", int'(bright), 1);
    chk("mid.r", int'(vgaR), 15);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    k_now = 0;
    first_k = -1;
    while (k_now < 2500 && first_k < 0) begin
      if (game_tick) first_k = k_now;
      else step();
    end
    chk("first_tick_after_rst", first_k, 1919);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4, gives the system clocks per pixel (100 MHz to 25 MHz).
REQ-002 Parameters H_TOTAL 800, H_SYNC 96, H_DISP_START 144, H_DISP_END 783 are horizontal timing in pixels.
REQ-003 Parameters V_TOTAL 525, V_SYNC 2, V_DISP_START 35, V_DISP_END 514 are vertical timing in lines.
REQ-004 Parameter TICK_FRAMES, default 1, gives the frames per game_tick pulse.
REQ-005 Port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port hCount, output, 10 bits: horizontal pixel counter, range 0..H_TOTAL-1.
REQ-008 Port vCount, output, 10 bits: vertical line counter, range 0..V_TOTAL-1.
REQ-009 Port bright, output, 1 bit: high while (hCount,vCount) is inside the display window.
REQ-010 Port pix_en, output, 1 bit: one-clk strobe once every CLK_DIV clocks.
REQ-011 Port rgb_in, input, 12 bits: pixel colour for the current hCount/vCount, formatted {R[3:0],G[3:0],B[3:0]}.
REQ-012 Ports vgaR, vgaG, vgaB, output, 4 bits each: registered colour to the DAC.
REQ-013 Ports hSync and vSync, output, 1 bit each: active-low syncs, delay-matched to the colour outputs.
REQ-014 Port game_tick, output, 1 bit: one-clk strobe used as the object-motion enable.

Function
REQ-015 A divider counter shall count 0..CLK_DIV-1 and wrap; pix_en is high only when the count equals CLK_DIV-1.
REQ-016 hCount shall advance only on pix_en; at H_TOTAL-1 it wraps to 0 and vCount advances by one.
REQ-017 vCount shall wrap from V_TOTAL-1 to 0 on the same pix_en on which hCount wraps.
REQ-018 bright shall be combinational: H_DISP_START<=hCount<=H_DISP_END and V_DISP_START<=vCount<=V_DISP_END, inclusive.
REQ-019 Raw hsync shall be low for hCount<H_SYNC; raw vsync shall be low for vCount<V_SYNC.
REQ-020 Output stage: on pix_en, register {vgaR,vgaG,vgaB} as rgb_in when bright, else 0.
REQ-021 On the same pix_en, register hSync and vSync from the raw syncs, giving a one-pixel latency on all DAC-side outputs.
REQ-022 Between pix_en strobes, all DAC-side outputs shall hold their values.
REQ-023 A frame counter, 0..TICK_FRAMES-1, shall advance on the pix_en where both hCount and vCount wrap to 0.
REQ-024 game_tick shall pulse for exactly one clk on the pix_en where the frame counter wraps.
REQ-025 TICK_FRAMES=1 shall give one game_tick per frame, the first at the end of the first full frame after reset.
REQ-026 Counter widths are 10 bits; no counter shall ever exceed its TOTAL-1 value.

Reset
REQ-027 While rst_n is low, the divider, hCount, vCount, the frame counter, and vgaR/G/B shall be 0.
REQ-028 While rst_n is low, hSync and vSync shall be 1 (inactive), and pix_en and game_tick shall be 0.
REQ-029 Reset asserted mid-line or mid-frame shall take effect immediately with no partial game_tick.
REQ-030 After rst_n deasserts, the first pix_en shall occur CLK_DIV clocks later.

Structure
REQ-031 The timing constants and the colour constants (RED, YELLOW, BLACK as 12-bit values) shall live in a shared package/include, vga_pkg, also used by the game logic.
REQ-032 One sub-module, vga_sync_counter (divider plus h/v counters), is natural; the output stage and tick logic stay in the top.

Verification
REQ-033 Release reset, run 2 frames -> pix_en period is 4 clks; hCount spans 0..799; vCount spans 0..524; one frame is 1,680,000 clks.
REQ-034 Check hSync on the DAC side -> low for exactly 96 pixels per line, starting one pixel after hCount=0; vSync low for exactly 2 lines.
REQ-035 Drive rgb_in=12'hF00 constantly -> vgaR=F only for registered pixels with hCount 144..783 and vCount 35..514; all other pixels give 0.
REQ-036 Set TICK_FRAMES=3 -> game_tick is a one-clk pulse every 3 frames, coincident with the (0,0) wrap.
REQ-037 Assert rst_n low at hCount=400, vCount=200 -> all counters are 0 and syncs are 1 asynchronously; no game_tick follows release until a full period has elapsed.
REQ-038 Drive a boundary pattern on rgb_in at hCount=143/144 and 783/784 -> colour appears exactly on pixels 144 and 783 only.
